// File: rtl/led_pattern_gen_pkg.sv
// Shared definitions for the LED pattern engine: mode encoding, button roles
// and the next/previous mode stepping rule.
package led_pattern_gen_pkg;

  typedef enum logic [1:0] {
    MODE_COUNT   = 2'd0,
    MODE_SCAN    = 2'd1,
    MODE_BREATHE = 2'd2,
    MODE_MIRROR  = 2'd3
  } mode_t;

  localparam int BTN_PAUSE = 0;
  localparam int BTN_NEXT  = 1;
  localparam int BTN_PREV  = 2;

  // Simultaneous next and previous presses cancel out.
  function automatic mode_t next_mode(input mode_t cur, input logic fwd, input logic back);
    logic [1:0] raw;
    raw = cur;
    if (fwd && !back) begin
      raw = raw + 2'd1;
    end else if (back && !fwd) begin
      raw = raw - 2'd1;
    end else begin
      raw = cur;
    end
    return mode_t'(raw);
  endfunction

endpackage

// File: rtl/led_pattern_gen_btn_debounce.sv
// One button: two-flop synchroniser followed by a mismatch counter that only
// lets the stable state follow after DEBOUNCE_CYC consecutive differing cycles.
module btn_debounce
  import led_pattern_gen_pkg::*;
#(
  parameter int DEBOUNCE_CYC = 250000
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_raw,
  output logic o_stable
);

  localparam int CNT_W = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYC - 1);

  logic             sync1_r;
  logic             sync2_r;
  logic             stable_r;
  logic [CNT_W-1:0] cnt_r;

  // synchroniser, mismatch counter and stable-state update
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sync1_r  <= 1'b0;
      sync2_r  <= 1'b0;
      stable_r <= 1'b0;
      cnt_r    <= '0;
    end else begin
      sync1_r <= i_raw;
      sync2_r <= sync1_r;
      if (sync2_r == stable_r) begin
        cnt_r <= '0;
      end else if (cnt_r == CNT_LAST) begin
        stable_r <= sync2_r;
        cnt_r    <= '0;
      end else begin
        cnt_r <= cnt_r + CNT_W'(1);
      end
    end
  end

  assign o_stable = stable_r;

endmodule

// File: rtl/led_pattern_gen.sv
// LED pattern engine: debounced button controls, prescaled step tick and the
// count / scan / breathe / mirror pattern datapath with a registered LED drive.
module led_pattern_gen
  import led_pattern_gen_pkg::*;
#(
  parameter int N_LED        = 8,
  parameter int N_BTN        = 7,
  parameter int PRESCALE_W   = 18,
  parameter int DEBOUNCE_CYC = 250000,
  parameter int PWM_W        = 8
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [N_BTN-1:0] i_btn,
  output logic [N_LED-1:0] o_led,
  output logic [1:0]       o_mode,
  output logic             o_tick
);

  localparam int POS_W = (N_LED > 1) ? $clog2(N_LED) : 1;
  localparam int N_MIR = (N_LED < N_BTN) ? N_LED : N_BTN;
  localparam logic [POS_W-1:0] POS_LAST = POS_W'(N_LED - 1);
  localparam logic [PWM_W-1:0] DUTY_MAX = {PWM_W{1'b1}};

  logic [N_BTN-1:0]      stable_s;
  logic [2:0]            stable_q_r;
  logic [2:0]            press_s;
  logic [PRESCALE_W-1:0] presc_r;
  logic                  tick_r;
  mode_t                 mode_r;
  mode_t                 mode_nxt_s;
  logic                  pause_r;
  logic                  advance_s;
  logic [N_LED-1:0]      step_r;
  logic [POS_W-1:0]      pos_r;
  logic                  pos_up_r;
  logic [PWM_W-1:0]      duty_r;
  logic                  duty_up_r;
  logic [PWM_W-1:0]      pwm_r;
  logic [N_LED-1:0]      led_r;
  logic [N_LED-1:0]      led_nxt_s;
  logic [N_LED-1:0]      mirror_s;

  genvar gi;
  generate
    for (gi = 0; gi < N_BTN; gi++) begin : g_btn
      btn_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_debounce (
        .i_clk    (i_clk),
        .i_rst_n  (i_rst_n),
        .i_raw    (i_btn[gi]),
        .o_stable (stable_s[gi])
      );
    end
  endgenerate

  // only the three control buttons need rising-edge detection
  assign press_s   = stable_s[2:0] & ~stable_q_r;
  assign advance_s = tick_r & ~pause_r;

  // mode stepping from next/previous presses
  always_comb begin
    mode_nxt_s = next_mode(mode_r, press_s[BTN_NEXT], press_s[BTN_PREV]);
  end

  // LED value for the current pattern state, registered below
  always_comb begin
    led_nxt_s = '0;
    mirror_s  = '0;
    mirror_s[N_MIR-1:0] = stable_s[N_MIR-1:0];
    case (mode_r)
      MODE_COUNT:   led_nxt_s = step_r;
      MODE_SCAN:    led_nxt_s = N_LED'(1'b1) << pos_r;
      MODE_BREATHE: led_nxt_s = (pwm_r < duty_r) ? {N_LED{1'b1}} : {N_LED{1'b0}};
      MODE_MIRROR:  led_nxt_s = mirror_s;
      default:      led_nxt_s = '0;
    endcase
  end

  // free-running prescaler and registered step tick
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      presc_r <= '0;
      tick_r  <= 1'b0;
    end else begin
      presc_r <= presc_r + PRESCALE_W'(1);
      tick_r  <= (presc_r == {PRESCALE_W{1'b1}});
    end
  end

  // controls, pattern state, PWM counter and registered LED drive
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      stable_q_r <= 3'b000;
      mode_r     <= MODE_COUNT;
      pause_r    <= 1'b0;
      step_r     <= '0;
      pos_r      <= '0;
      pos_up_r   <= 1'b1;
      duty_r     <= '0;
      duty_up_r  <= 1'b1;
      pwm_r      <= '0;
      led_r      <= '0;
    end else begin
      stable_q_r <= stable_s[2:0];
      pwm_r      <= pwm_r + PWM_W'(1);
      led_r      <= led_nxt_s;
      mode_r     <= mode_nxt_s;
      if (press_s[BTN_PAUSE]) begin
        pause_r <= ~pause_r;
      end
      // a mode change restarts every pattern and wins over a same-cycle advance
      if (mode_nxt_s != mode_r) begin
        step_r    <= '0;
        pos_r     <= '0;
        pos_up_r  <= 1'b1;
        duty_r    <= '0;
        duty_up_r <= 1'b1;
      end else if (advance_s) begin
        case (mode_r)
          MODE_COUNT: step_r <= step_r + N_LED'(1);
          MODE_SCAN: begin
            if (POS_LAST == '0) begin
              pos_r <= '0;
            end else if (pos_up_r) begin
              if (pos_r == POS_LAST) begin
                pos_up_r <= 1'b0;
                pos_r    <= pos_r - POS_W'(1);
              end else begin
                pos_r <= pos_r + POS_W'(1);
              end
            end else begin
              if (pos_r == '0) begin
                pos_up_r <= 1'b1;
                pos_r    <= pos_r + POS_W'(1);
              end else begin
                pos_r <= pos_r - POS_W'(1);
              end
            end
          end
          MODE_BREATHE: begin
            if (duty_up_r) begin
              if (duty_r == DUTY_MAX) begin
                duty_up_r <= 1'b0;
                duty_r    <= duty_r - PWM_W'(1);
              end else begin
                duty_r <= duty_r + PWM_W'(1);
              end
            end else begin
              if (duty_r == '0) begin
                duty_up_r <= 1'b1;
                duty_r    <= duty_r + PWM_W'(1);
              end else begin
                duty_r <= duty_r - PWM_W'(1);
              end
            end
          end
          default: step_r <= step_r;
        endcase
      end
    end
  end

  assign o_led  = led_r;
  assign o_mode = mode_r;
  assign o_tick = tick_r;

endmodule

// File: tb/tb_led_pattern_gen.sv
// Self-checking bench for led_pattern_gen: directed sequences, a control table
// and a randomized run against a pattern model built from triangle waves.
module tb_led_pattern_gen;

  localparam int N_LED        = 8;
  localparam int N_BTN        = 7;
  localparam int PRESCALE_W   = 2;
  localparam int DEBOUNCE_CYC = 4;
  localparam int PWM_W        = 3;

  logic             clk   = 1'b0;
  logic             rst_n = 1'b0;
  logic [N_BTN-1:0] btn   = '0;
  logic [N_LED-1:0] led;
  logic [1:0]       mode;
  logic             tick;

  led_pattern_gen #(
    .N_LED(N_LED), .N_BTN(N_BTN), .PRESCALE_W(PRESCALE_W),
    .DEBOUNCE_CYC(DEBOUNCE_CYC), .PWM_W(PWM_W)
  ) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_btn(btn),
    .o_led(led), .o_mode(mode), .o_tick(tick)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // reference model state
  int               m_edges;
  int               m_n;
  int               m_mode;
  bit               m_pause;
  bit               m_tick;
  logic [N_LED-1:0] m_led;
  bit [N_BTN-1:0]   m_d1, m_d2, m_stable, m_stable_q;
  int               m_run [N_BTN];

  typedef struct {
    logic [N_BTN-1:0] b;
    int               hold;
    logic [1:0]       exp_mode;
  } ctl_vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // pattern as a function of advances since the mode was entered
  function automatic logic [N_LED-1:0] pattern(input int md, input int n, input int pwm,
                                               input bit [N_BTN-1:0] st);
    int scan_per;
    int duty_max;
    int p;
    int duty;
    logic [N_LED-1:0] r;
    scan_per = 2 * (N_LED - 1);
    duty_max = (1 << PWM_W) - 1;
    r = '0;
    case (md)
      0: r = N_LED'(n % (1 << N_LED));
      1: begin
        p = n % scan_per;
        if (p >= N_LED) p = scan_per - p;
        r[p] = 1'b1;
      end
      2: begin
        p = n % (2 * duty_max);
        duty = (p <= duty_max) ? p : 2 * duty_max - p;
        r = (pwm < duty) ? '1 : '0;
      end
      default: for (int i = 0; i < N_BTN; i++) r[i] = st[i];
    endcase
    return r;
  endfunction

  task automatic model_reset();
    m_edges = 0; m_n = 0; m_mode = 0; m_pause = 0; m_tick = 0; m_led = '0;
    m_d1 = '0; m_d2 = '0; m_stable = '0; m_stable_q = '0;
    for (int i = 0; i < N_BTN; i++) m_run[i] = 0;
  endtask

  task automatic model_edge(input logic [N_BTN-1:0] b);
    int pre;
    int md_new;
    bit [N_BTN-1:0] press;
    pre = m_edges;
    m_edges++;
    m_led = pattern(m_mode, m_n, pre % (1 << PWM_W), m_stable);
    press = m_stable & ~m_stable_q;
    md_new = m_mode;
    if (press[1] && !press[2]) md_new = (m_mode + 1) % 4;
    else if (press[2] && !press[1]) md_new = (m_mode + 3) % 4;
    if (md_new != m_mode) m_n = 0;
    else if (m_tick && !m_pause) m_n++;
    m_mode = md_new;
    if (press[0]) m_pause = !m_pause;
    m_tick = ((pre % (1 << PRESCALE_W)) == (1 << PRESCALE_W) - 1);
    m_stable_q = m_stable;
    // stable follows once the synced value has differed for DEBOUNCE_CYC edges
    for (int i = 0; i < N_BTN; i++) begin
      if (m_d2[i] != m_stable[i]) begin
        m_run[i]++;
        if (m_run[i] == DEBOUNCE_CYC) begin
          m_stable[i] = m_d2[i];
          m_run[i] = 0;
        end
      end else begin
        m_run[i] = 0;
      end
    end
    m_d2 = m_d1;
    m_d1 = b;
  endtask

  task automatic step(input logic [N_BTN-1:0] b);
    btn = b;
    @(posedge clk);
    model_edge(b);
    @(negedge clk);
    check("led", led, m_led);
    check("mode", mode, m_mode);
    check("tick", tick, m_tick);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    btn = '0;
    #1;
    check("rst_led", led, 8'h00);
    check("rst_mode", mode, 2'd0);
    check("rst_tick", tick, 1'b0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic press_release(input logic [N_BTN-1:0] b);
    repeat (8) step(b);
    repeat (8) step('0);
  endtask

  ctl_vec_t ctl [7];
  int       tick_cnt;

  initial begin
    ctl[0] = '{b: 7'h02, hold: 3, exp_mode: 2'd1};
    ctl[1] = '{b: 7'h04, hold: 8, exp_mode: 2'd0};
    ctl[2] = '{b: 7'h04, hold: 8, exp_mode: 2'd3};
    ctl[3] = '{b: 7'h06, hold: 8, exp_mode: 2'd3};
    ctl[4] = '{b: 7'h02, hold: 8, exp_mode: 2'd0};
    ctl[5] = '{b: 7'h02, hold: 8, exp_mode: 2'd1};
    ctl[6] = '{b: 7'h06, hold: 2, exp_mode: 2'd1};

    // count mode, tick cadence, then asynchronous reset mid-run
    do_reset();
    repeat (40) step('0);
    check("count_after_40", led, 8'd9);
    do_reset();

    // next-button latency and scan bounce
    for (int i = 1; i <= 7; i++) begin
      step(7'h02);
      if (i == 6) check("mode_before_latency", mode, 2'd0);
      if (i == 7) check("mode_at_latency", mode, 2'd1);
    end
    step(7'h02);
    check("scan_first", led, 8'h01);
    repeat (70) step(7'h02);
    repeat (8) step('0);

    // control table: glitches, wrap both ways, simultaneous presses
    foreach (ctl[v]) begin
      repeat (ctl[v].hold) step(ctl[v].b);
      repeat (10) step('0);
      check($sformatf("ctl_mode_%0d", v), mode, ctl[v].exp_mode);
    end

    // pause freezes the count while the tick keeps running
    do_reset();
    press_release(7'h01);
    tick_cnt = 0;
    for (int i = 0; i < 16; i++) begin
      step('0);
      check("paused_led", led, 8'h01);
      if (tick) tick_cnt++;
    end
    check("paused_ticks", tick_cnt, 4);
    press_release(7'h01);
    check("resumed_led", led, 8'h03);
    repeat (20) step('0);

    // breathe ramp
    do_reset();
    press_release(7'h02);
    press_release(7'h02);
    check("breathe_mode", mode, 2'd2);
    repeat (150) step('0);

    // mirror entered via previous-button wrap from count
    do_reset();
    repeat (12) step(7'h55);
    check("mirror_mode", mode, 2'd3);
    check("mirror_led", led, 8'h55);

    // randomized buttons against the model
    do_reset();
    for (int s = 0; s < 300; s++) begin
      logic [N_BTN-1:0] rb;
      int hold;
      rb = N_BTN'($urandom);
      hold = $urandom_range(1, 12);
      repeat (hold) step(rb);
      if (s == 150) do_reset();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/led_pattern_gen.md
Name: led_pattern_gen

Overview:
Parametrised LED pattern engine for the board-level blink designs. Drives N_LED outputs from a prescaled step tick in one of four selectable modes: binary count, bouncing scanner, PWM breathe, and button mirror. Buttons are synchronised and debounced internally. Mode select, next/previous, and pause come from dedicated buttons. Sits directly between top-level btn/led pins and the board clock.

Parameters:
N_LED, 8, number of LED outputs (>=1)
N_BTN, 7, number of button inputs (>=3)
PRESCALE_W, 18, step tick period = 2^PRESCALE_W clocks
DEBOUNCE_CYC, 250000, stable cycles required before a debounced button changes (>=1); 10 ms at 25 MHz
PWM_W, 8, breathe-mode PWM resolution in bits

Ports:
i_clk  in  1  system clock
i_rst_n  in  1  asynchronous active-low reset
i_btn  in  N_BTN  raw button inputs, active-high, asynchronous
o_led  out  N_LED  registered LED drive, active-high
o_mode  out  2  current mode: 0 COUNT, 1 SCAN, 2 BREATHE, 3 MIRROR
o_tick  out  1  one-cycle step tick pulse, registered

Behaviour:
- Clock and reset: one clock, i_clk. Reset is i_rst_n, asynchronous and active-low.
- State on reset:
  - o_led=0, o_mode=0, o_tick=0.
  - Prescaler=0, step counter=0, scan pos=0, scan dir=up, duty=0, duty dir=up.
  - pause=0; sync flops, debounced state and debounce counters=0.
  - Reset release has no glitch requirement beyond this.
- Input conditioning, per button:
  - 2-flop synchroniser.
  - Debounce counter increments while synced != stable and clears when they are equal.
  - When the counter reaches DEBOUNCE_CYC-1 with the mismatch still present, stable takes the synced value on the next edge.
  - A glitch shorter than DEBOUNCE_CYC cycles never changes stable.
  - press[i] = stable[i] & ~stable_q[i] (rising edge only).
- Input-to-mode latency: a raw edge at cycle k changes stable at k+2+DEBOUNCE_CYC. Any mode or pause effect is visible at k+3+DEBOUNCE_CYC.
- Controls:
  - press[1]: mode = mode+1, wraps 3->0.
  - press[2]: mode = mode-1, wraps 0->3.
  - press[1] and press[2] in the same cycle: mode unchanged.
  - press[0]: toggles pause.
- Mode change:
  - Clears the step counter, scan pos/dir and duty/dir to their reset values in the same edge.
  - pause is not affected.
- Prescaler:
  - Free-running PRESCALE_W-bit counter that wraps.
  - o_tick=1 for exactly the one cycle after the counter equals all-ones.
  - The prescaler and o_tick run regardless of pause.
  - Pattern state advances only on cycles with o_tick=1 and pause=0.
- COUNT mode: step counter is N_LED bits and wraps. o_led = step counter.
- SCAN mode:
  - o_led = one-hot at pos.
  - On advance, pos moves in dir. At pos=N_LED-1 going up, dir flips and pos decrements on the same advance; symmetric at pos=0 going down.
  - N_LED=1: pos stays 0, o_led=1.
- BREATHE mode:
  - Free-running PWM_W-bit pwm counter.
  - o_led = all ones when pwm_cnt < duty, else 0.
  - On advance, duty moves in dir. At 2^PWM_W-1 going up it reverses and decrements; at 0 going down it reverses and increments.
  - duty=0 gives constant off.
- MIRROR mode: o_led[i] = stable[i] for i < min(N_LED, N_BTN); remaining bits are 0.
- Output registration: o_led is registered. Its value reflects state as of the previous edge, so there is 1-cycle latency from any state update.
- Mid-operation reset: all state returns to reset values immediately, including partial debounce counts.

Decomposition:
- Shared package:
  - mode encoding constants MODE_COUNT/SCAN/BREATHE/MIRROR.
  - button index constants BTN_PAUSE=0, BTN_NEXT=1, BTN_PREV=2.
  - 2-bit mode typedef.
- Sub-module btn_debounce holds one button's synchroniser, counter and stable register, parametrised by DEBOUNCE_CYC. It is instantiated N_BTN times via generate.
- The prescaler, control logic and pattern datapath stay in led_pattern_gen.

Test Plan:
Bench parameters: N_LED=8, N_BTN=7, PRESCALE_W=2, DEBOUNCE_CYC=4, PWM_W=3.
1. Reset then run 40 cycles in COUNT -> o_tick every 4th cycle. o_led steps 0,1,2,... one per tick. Reassert i_rst_n mid-run -> o_led=0, o_mode=0 immediately.
2. Raise i_btn[1] at cycle k and hold -> o_mode=1 exactly at k+7, o_led=0x01. Subsequent ticks give 0x02..0x80 then 0x40, 0x20 (bounce).
3. 3-cycle pulse on i_btn[1] -> o_mode unchanged. Press i_btn[2] from mode 0 -> o_mode=3. Press btn[1] and btn[2] simultaneously -> no change.
4. In COUNT, press i_btn[0] -> o_led frozen while o_tick still pulses. Press again -> counting resumes from the frozen value.
5. BREATHE mode -> duty ramps 0..7..0. At duty=3, o_led=0xFF for 3 of every 8 cycles. At duty=0, o_led stays 0.
6. MIRROR mode, hold i_btn=7'b1010101 -> o_led=8'b01010101 after debounce latency. o_led[7] stays 0.
